// File: rtl/audio_flash_pkg.sv
// Shared definitions for the audio flash read and write paths.
package audio_flash_pkg;

  // Word-address geometry of the audio region in flash.
  localparam int AUDIO_ADDR_WIDTH = 23;
  localparam logic [AUDIO_ADDR_WIDTH-1:0] AUDIO_MAX_ADDR = 23'h7FFFF;

  // Write master state.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Byte lane index within a 32-bit word.
  typedef logic [1:0] lane_t;

  // Byte enable mask with the lowest n lanes set (n = 0..4).
  function automatic logic [3:0] lanes_to_be(input logic [2:0] n);
    logic [4:0] m;
    m = (5'd1 << n) - 5'd1;
    return m[3:0];
  endfunction

endpackage

// File: rtl/audio_flash_writer_packer.sv
// Packs 8-bit samples into little-endian 32-bit words; a flush emits a
// zero-padded partial word with byte enables for the filled lanes only.
module sample_word_packer
  import audio_flash_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sampleValid,
  input  logic [7:0]  sampleData,
  input  logic        flush,
  output logic        wordReady,
  output logic [31:0] word,
  output logic [3:0]  wordBe
);

  lane_t       lane_q, lane_d;
  logic [31:0] bytes_q, bytes_d;
  logic [31:0] assembled;
  logic [2:0]  count;

  // Merge the incoming sample into the current word and decide whether it is emitted.
  always_comb begin
    assembled = bytes_q;
    count     = {1'b0, lane_q};
    if (sampleValid) begin
      assembled[{lane_q, 3'b000} +: 8] = sampleData;
      count = count + 3'd1;
    end
    wordReady = (count == 3'd4) || (flush && (count != 3'd0));
    word      = assembled;
    wordBe    = lanes_to_be(count);
    if (wordReady) begin
      // The word leaves whether or not the top accepts it, so start fresh.
      lane_d  = '0;
      bytes_d = '0;
    end else begin
      lane_d  = count[1:0];
      bytes_d = assembled;
    end
  end

  // Lane counter and assembly register; cleared so unfilled lanes read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= '0;
      bytes_q <= '0;
    end else begin
      lane_q  <= lane_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: rtl/audio_flash_writer.sv
// Avalon-MM write master that stores packed audio words into a wrapping
// region of flash. The single pending buffer is the registered write
// request itself, so a word loaded at an edge is presented right after it.
module audio_flash_writer
  import audio_flash_pkg::*;
#(
  parameter int                    ADDR_WIDTH = AUDIO_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR   = ADDR_WIDTH'(AUDIO_MAX_ADDR),
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sampleValid,
  input  logic [7:0]            sampleData,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic [31:0]           writeData,
  output logic [3:0]            byteEnable,
  input  logic                  waitRequest,
  output logic                  busy,
  output logic                  overflow,
  output logic                  wrapped
);

  logic        word_ready;
  logic [31:0] word;
  logic [3:0]  word_be;

  sample_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .sampleValid (sampleValid),
    .sampleData  (sampleData),
    .flush       (flush),
    .wordReady   (word_ready),
    .word        (word),
    .wordBe      (word_be)
  );

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  ovf_q, ovf_d;
  logic                  wrap_q, wrap_d;
  logic                  accept;
  logic                  load;

  // Next-state: accept advances the address, a ready word loads the buffer if it is free.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wrap_d  = 1'b0;
    accept  = (state_q == WRITE) && !waitRequest;
    // The buffer is free when idle, or when its current word leaves this cycle.
    load    = word_ready && ((state_q == IDLE) || accept);
    ovf_d   = ovf_q || (word_ready && !load);
    case (state_q)
      IDLE: begin
        if (load) state_d = WRITE;
      end
      WRITE: begin
        if (accept) begin
          wrap_d  = (addr_q == MAX_ADDR);
          addr_d  = (addr_q == MAX_ADDR) ? START_ADDR : addr_q + ADDR_WIDTH'(1);
          // A word loading on the accept edge keeps the request up back-to-back.
          state_d = load ? WRITE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      wdata_d = word;
      be_d    = word_be;
    end
  end

  // State, address counter, registered write payload and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= START_ADDR;
      wdata_q <= '0;
      be_q    <= '0;
      ovf_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ovf_q   <= ovf_d;
      wrap_q  <= wrap_d;
    end
  end

  assign write      = (state_q == WRITE);
  assign address    = addr_q;
  assign writeData  = wdata_q;
  assign byteEnable = be_q;
  // Pending buffer full and write in progress coincide in this design.
  assign busy       = write;
  assign overflow   = ovf_q;
  assign wrapped    = wrap_q;

endmodule

// File: tb/tb_audio_flash_writer.sv
// Scoreboard bench for audio_flash_writer: a byte-queue reference model
// predicts each written word; a monitor compares presented writes.
module tb_audio_flash_writer;

  localparam int AW = 23;
  localparam logic [AW-1:0] MAXA  = 23'h7FFFF;
  localparam logic [AW-1:0] START = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b1, reset_w = 1'b1;
  logic          sampleValid = 1'b0, flush = 1'b0, waitRequest = 1'b0;
  logic [7:0]    sampleData = '0;
  logic [AW-1:0] address, address_w;
  logic          write, write_w, busy, busy_w, overflow, overflow_w, wrapped, wrapped_w;
  logic [31:0]   writeData, writeData_w;
  logic [3:0]    byteEnable, byteEnable_w;

  always #5 clk = ~clk;

  audio_flash_writer dut (
    .clk(clk), .reset(reset), .sampleValid(sampleValid), .sampleData(sampleData),
    .flush(flush), .address(address), .write(write), .writeData(writeData),
    .byteEnable(byteEnable), .waitRequest(waitRequest), .busy(busy),
    .overflow(overflow), .wrapped(wrapped)
  );

  audio_flash_writer #(.START_ADDR(MAXA)) dut_w (
    .clk(clk), .reset(reset_w), .sampleValid(sampleValid), .sampleData(sampleData),
    .flush(flush), .address(address_w), .write(write_w), .writeData(writeData_w),
    .byteEnable(byteEnable_w), .waitRequest(waitRequest), .busy(busy_w),
    .overflow(overflow_w), .wrapped(wrapped_w)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
  } exp_t;

  exp_t          exp_q[$];
  logic [7:0]    m_bytes[$];
  bit            m_busy = 0, m_ovf = 0, m_wrap = 0;
  logic [AW-1:0] m_addr = START;
  int            checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: one-word slot, byte list, wrapping word counter.
  task automatic model_step(input bit sv, input logic [7:0] d, input bit fl,
                            input bit wr, input bit rs);
    bit acc;
    logic [31:0] data;
    int n;
    if (rs) begin
      m_bytes.delete(); exp_q.delete();
      m_busy = 0; m_ovf = 0; m_wrap = 0; m_addr = START;
      return;
    end
    acc = m_busy && !wr;
    m_wrap = acc && (m_addr == MAXA);
    if (acc) begin
      m_addr = (m_addr == MAXA) ? START : m_addr + 1;
      m_busy = 0;
    end
    if (sv) m_bytes.push_back(d);
    n = m_bytes.size();
    if (n == 4 || (fl && n > 0)) begin
      data = 0;
      for (int i = 0; i < n; i++) data = data | (32'(m_bytes[i]) << (8 * i));
      if (!m_busy) begin
        exp_q.push_back('{a: m_addr, d: data, be: 4'((1 << n) - 1)});
        m_busy = 1;
      end else begin
        m_ovf = 1;
      end
      m_bytes.delete();
    end
  endtask

  task automatic cycle(input bit sv, input logic [7:0] d, input bit fl, input bit wr,
                       input bit rs = 1'b0);
    sampleValid = sv; sampleData = d; flush = fl; waitRequest = wr; reset = rs;
    @(posedge clk);
    model_step(sv, d, fl, wr, rs);
    @(negedge clk);
    chk("write", 32'(write), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("wrapped", 32'(wrapped), 32'(m_wrap));
  endtask

  // Monitor: compare every presented write against the scoreboard head.
  always @(negedge clk) begin
    if (write) begin
      if (exp_q.size() == 0) chk("spurious_write", 32'(write), 32'd0);
      else begin
        chk("wr_addr", 32'(address), 32'(exp_q[0].a));
        chk("wr_data", writeData, exp_q[0].d);
        chk("wr_be", 32'(byteEnable), 32'(exp_q[0].be));
      end
    end
  end

  // Retire the head word on the accepting edge.
  always @(posedge clk) begin
    if (!reset && write && !waitRequest && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  initial begin
    // Reset values
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("rst_write", 32'(write), 0);
    chk("rst_addr", 32'(address), 32'(START));
    chk("rst_data", writeData, 0);
    chk("rst_be", 32'(byteEnable), 0);

    // Single word, no stall
    cycle(1, 8'h11, 0, 0); cycle(1, 8'h22, 0, 0); cycle(1, 8'h33, 0, 0); cycle(1, 8'h44, 0, 0);
    chk("t1_write", 32'(write), 1);
    chk("t1_data", writeData, 32'h44332211);
    chk("t1_be", 32'(byteEnable), 32'hF);
    chk("t1_addr", 32'(address), 0);
    cycle(0, 0, 0, 0);
    chk("t1_idle_addr", 32'(address), 1);

    // Stalled write holds its outputs
    cycle(1, 8'h55, 0, 1); cycle(1, 8'h66, 0, 1); cycle(1, 8'h77, 0, 1); cycle(1, 8'h88, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1);
      chk("t2_hold_addr", 32'(address), 1);
      chk("t2_hold_data", writeData, 32'h88776655);
    end
    cycle(0, 0, 0, 0);
    chk("t2_addr_once", 32'(address), 2);

    // Two words; the second loads on the accept edge of the first (back-to-back)
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'hA0 + i), 0, 1);
    cycle(1, 8'hA7, 0, 0);
    chk("t3_b2b_write", 32'(write), 1);
    chk("t3_b2b_data", writeData, 32'hA7A6A5A4);
    chk("t3_b2b_addr", 32'(address), 3);
    cycle(0, 0, 0, 0);
    chk("t3_ovf", 32'(overflow), 0);

    // Flush partial word, flush with empty lane, sample+flush on lane 3
    cycle(1, 8'hAA, 0, 0); cycle(1, 8'hBB, 0, 0); cycle(0, 0, 1, 0);
    chk("t4_data", writeData, 32'h0000BBAA);
    chk("t4_be", 32'(byteEnable), 32'h3);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("t4_noop_write", 32'(write), 0);
    cycle(1, 8'h01, 0, 0); cycle(1, 8'h02, 0, 0); cycle(1, 8'h03, 0, 0); cycle(1, 8'h04, 1, 0);
    chk("t4_l3_data", writeData, 32'h04030201);
    chk("t4_l3_be", 32'(byteEnable), 32'hF);
    cycle(0, 0, 0, 0);

    // Stall while a second word completes: it is dropped and overflow sticks
    for (int i = 0; i < 12; i++) cycle(1, 8'(8'hC0 + i), 0, 1);
    chk("t5_ovf", 32'(overflow), 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    chk("t5_ovf_sticky", 32'(overflow), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(15, 0) == 0,
            $urandom_range(2, 0) == 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    chk("drained", 32'(exp_q.size()), 0);

    // Reset during a stalled write
    cycle(0, 0, 0, 0, 1);
    cycle(1, 8'h12, 0, 1); cycle(1, 8'h34, 0, 1); cycle(1, 8'h56, 0, 1); cycle(1, 8'h78, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    chk("rst_mid_write", 32'(write), 0);
    chk("rst_mid_addr", 32'(address), 32'(START));
    chk("rst_mid_data", writeData, 0);
    chk("rst_mid_be", 32'(byteEnable), 0);

    // Wrap at the end of the region
    cycle(0, 0, 0, 0);
    reset_w = 1'b0;
    cycle(1, 8'hD1, 0, 0); cycle(1, 8'hD2, 0, 0); cycle(1, 8'hD3, 0, 0); cycle(1, 8'hD4, 0, 0);
    chk("t6_write", 32'(write_w), 1);
    chk("t6_addr", 32'(address_w), 32'(MAXA));
    chk("t6_data", writeData_w, 32'hD4D3D2D1);
    chk("t6_wrap_before", 32'(wrapped_w), 0);
    cycle(0, 0, 0, 0);
    chk("t6_addr_wrapped", 32'(address_w), 32'(MAXA));
    chk("t6_wrap_pulse", 32'(wrapped_w), 1);
    cycle(0, 0, 0, 0);
    chk("t6_wrap_end", 32'(wrapped_w), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
